execute_muldiv: RTL and testbench
=================================

EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data path width (even, >=8).
REQ-002 SHALL have parameter IMM_WIDTH, default 16, immediate width, sign-extended to DWIDTH.
REQ-003 SHALL have parameter PC_WIDTH, default 32, program counter width.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 es_clk  in  1  clock; all state updates on rising edge.
REQ-006 es_rst  in  1  synchronous active-high reset.
REQ-007 es_i_ce  in  1  instruction valid.
REQ-008 es_i_alu_src  in  1  1 = operand B is sext(imm), 0 = rt.
REQ-009 es_i_branch  in  1  instruction is a branch.
REQ-010 es_i_pc  in  PC_WIDTH  PC of the instruction.
REQ-011 es_i_imm  in  IMM_WIDTH  immediate.
REQ-012 es_i_alu_op  in  6  MIPS opcode.
REQ-013 es_i_alu_funct  in  6  MIPS funct (R-type only).
REQ-014 es_i_data_rs, es_i_data_rt  in  DWIDTH each  source operands.
REQ-015 es_o_alu_value  out  DWIDTH  registered result.
REQ-016 es_o_alu_pc  out  PC_WIDTH  registered branch target.
REQ-017 es_o_opcode, es_o_funct  out  6 each  registered copy of the accepted opcode/funct.
REQ-018 es_o_zero  out  1  registered (A - B == 0).
REQ-019 es_o_ce  out  1  result valid, one-cycle pulse per completed instruction.
REQ-020 es_o_change_pc  out  1  taken branch.
REQ-021 es_o_stall  out  1  multiply/divide unit busy; upstream SHALL hold inputs.

Function
REQ-022 Accept: instruction accepted on an edge where es_i_ce=1 and es_o_stall=0; inputs otherwise ignored.
REQ-023 Single-cycle ops: outputs registered on the accept edge with es_o_ce=1 (latency 1).
REQ-024 R-type funct: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010 (signed), MFHI 010000 -> HI, MFLO 010010 -> LO; add/sub wrap modulo 2^DWIDTH, no overflow trap.
REQ-025 Opcodes ADDI 001000, LW 100011, SW 101011 -> A + sext(imm); BEQ 000100, BNE 000101 -> A - B.
REQ-026 es_o_alu_pc = pc + 4 + (sext(imm) << 2), modulo 2^PC_WIDTH, registered every accept.
REQ-027 es_o_change_pc = es_i_branch & ((BEQ & zero) | (BNE & ~zero)); 0 for all other accepts.
REQ-028 Unknown opcode/funct: es_o_alu_value = 0, es_o_ce = 1.
REQ-029 MULT 011000 / MULTU 011001 / DIV 011010 / DIVU 011011: FSM IDLE -> BUSY on accept; iteration counter loaded with DWIDTH.
REQ-030 BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle; es_o_stall=1 for exactly DWIDTH cycles after the accept edge.
REQ-031 Last BUSY edge: write HI/LO, es_o_ce=1, es_o_alu_value=0, FSM -> IDLE; next instruction acceptable on the following edge.
REQ-032 Multiply: {HI,LO} = 2*DWIDTH-bit product; signed ops use magnitudes, product negated if signs differ.
REQ-033 Divide: LO = quotient truncated toward zero, HI = remainder with sign of dividend.
REQ-034 Divide by zero: no iteration; next edge HI = rs, LO = all ones, es_o_ce=1, es_o_stall never asserted.
REQ-035 Signed DIV of most-negative by -1: LO = most-negative, HI = 0.
REQ-036 es_i_ce=0 in IDLE: es_o_ce=0, es_o_change_pc=0, other outputs hold.
REQ-037 While BUSY, es_o_ce=0 and es_o_change_pc=0 except on the completion edge.

Reset
REQ-038 es_rst=1 on an edge: all outputs 0, HI=LO=0, FSM IDLE, counter 0; reset mid-BUSY aborts the operation without writing HI/LO.

Verification
REQ-039 ADD rs=5 rt=4 ce=1 -> next edge alu_value=9, ce=1, change_pc=0; SUB same -> 1.
REQ-040 BEQ pc=10 imm=10 rs=rt=5 branch=1 -> alu_pc=54, zero=1, change_pc=1; BNE same operands -> change_pc=0.
REQ-041 MULT rs=-3 rt=7 -> stall high 32 cycles, then ce=1; MFHI -> 0xFFFFFFFF, MFLO -> 0xFFFFFFEB (-21).
REQ-042 DIV rs=-7 rt=2 -> LO=-3, HI=-1; DIVU 7/0 -> no stall, HI=7, LO=0xFFFFFFFF.
REQ-043 Reset asserted at cycle 10 of MULTU 0xFFFFFFFF*2 -> stall=0, all outputs 0 next edge, MFLO -> 0.
REQ-044 ADD held with ce=1 during BUSY -> ignored until stall falls, then accepted exactly once.

Source files
------------

// File: rtl/execute_muldiv_if.sv
// Execute-stage handshake bundle: issue-side inputs and registered results
// of the ALU / multiply-divide stage.
interface execute_muldiv_if #(
    parameter int DWIDTH    = 32,
    parameter int IMM_WIDTH = 16,
    parameter int PC_WIDTH  = 32
);
    logic                 es_i_ce;
    logic                 es_i_alu_src;
    logic                 es_i_branch;
    logic [PC_WIDTH-1:0]  es_i_pc;
    logic [IMM_WIDTH-1:0] es_i_imm;
    logic [5:0]           es_i_alu_op;
    logic [5:0]           es_i_alu_funct;
    logic [DWIDTH-1:0]    es_i_data_rs;
    logic [DWIDTH-1:0]    es_i_data_rt;

    logic [DWIDTH-1:0]    es_o_alu_value;
    logic [PC_WIDTH-1:0]  es_o_alu_pc;
    logic [5:0]           es_o_opcode;
    logic [5:0]           es_o_funct;
    logic                 es_o_zero;
    logic                 es_o_ce;
    logic                 es_o_change_pc;
    logic                 es_o_stall;

    modport master (
        output es_i_ce, es_i_alu_src, es_i_branch, es_i_pc, es_i_imm,
        output es_i_alu_op, es_i_alu_funct, es_i_data_rs, es_i_data_rt,
        input  es_o_alu_value, es_o_alu_pc, es_o_opcode, es_o_funct,
        input  es_o_zero, es_o_ce, es_o_change_pc, es_o_stall
    );

    modport slave (
        input  es_i_ce, es_i_alu_src, es_i_branch, es_i_pc, es_i_imm,
        input  es_i_alu_op, es_i_alu_funct, es_i_data_rs, es_i_data_rt,
        output es_o_alu_value, es_o_alu_pc, es_o_opcode, es_o_funct,
        output es_o_zero, es_o_ce, es_o_change_pc, es_o_stall
    );
endinterface

// File: rtl/execute_muldiv.sv
// MIPS execute stage: single-cycle ALU plus an iterative
// shift-add multiplier / restoring divider writing HI/LO.
module execute_muldiv #(
    parameter int DWIDTH    = 32,
    parameter int IMM_WIDTH = 16,
    parameter int PC_WIDTH  = 32
) (
    input  logic             es_clk,
    input  logic             es_rst,
    execute_muldiv_if.slave  bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] F_ADD    = 6'b100000;
    localparam logic [5:0] F_SUB    = 6'b100010;
    localparam logic [5:0] F_AND    = 6'b100100;
    localparam logic [5:0] F_OR     = 6'b100101;
    localparam logic [5:0] F_SLT    = 6'b101010;
    localparam logic [5:0] F_MFHI   = 6'b010000;
    localparam logic [5:0] F_MFLO   = 6'b010010;
    localparam logic [5:0] F_MULT   = 6'b011000;
    localparam logic [5:0] F_MULTU  = 6'b011001;
    localparam logic [5:0] F_DIV    = 6'b011010;
    localparam logic [5:0] F_DIVU   = 6'b011011;
    localparam int         CW       = $clog2(DWIDTH + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t               r_state;
    state_t               w_state_n;
    logic [CW-1:0]        r_cnt;
    logic [DWIDTH-1:0]    r_hi;
    logic [DWIDTH-1:0]    r_lo;
    logic [DWIDTH-1:0]    r_ph;
    logic [DWIDTH-1:0]    r_pl;
    logic [DWIDTH-1:0]    r_mcand;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [DWIDTH-1:0]    r_val;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [5:0]           r_op;
    logic [5:0]           r_funct;
    logic                 r_zero;
    logic                 r_ce;
    logic                 r_chg;

    logic                 w_stall;
    logic                 w_done;
    logic                 w_accept;
    logic [DWIDTH-1:0]    w_imm_ext;
    logic [PC_WIDTH-1:0]  w_imm_pc;
    logic [PC_WIDTH-1:0]  w_br_pc;
    logic [DWIDTH-1:0]    w_a;
    logic [DWIDTH-1:0]    w_b;
    logic [DWIDTH-1:0]    w_diff;
    logic                 w_zero;
    logic                 w_chg;
    logic [DWIDTH-1:0]    w_alu;
    logic                 w_is_md;
    logic                 w_md_div;
    logic                 w_md_sgn;
    logic                 w_div0;
    logic                 w_rs_neg;
    logic                 w_rt_neg;
    logic [DWIDTH-1:0]    w_rs_mag;
    logic [DWIDTH-1:0]    w_rt_mag;
    logic [DWIDTH:0]      w_sum;
    logic [DWIDTH:0]      w_shl;
    logic                 w_ge;
    logic [DWIDTH-1:0]    w_ph_n;
    logic [DWIDTH-1:0]    w_pl_n;
    logic [2*DWIDTH-1:0]  w_prod;
    logic [DWIDTH-1:0]    w_hi_res;
    logic [DWIDTH-1:0]    w_lo_res;

    // Operand selection and branch target
    assign w_imm_ext = DWIDTH'($signed(bus.es_i_imm));
    assign w_imm_pc  = PC_WIDTH'($signed(bus.es_i_imm));
    assign w_br_pc   = bus.es_i_pc + PC_WIDTH'(4) + (w_imm_pc << 2);
    assign w_a       = bus.es_i_data_rs;
    assign w_b       = bus.es_i_alu_src ? w_imm_ext : bus.es_i_data_rt;
    assign w_diff    = w_a - w_b;
    assign w_zero    = (w_diff == '0);
    assign w_chg     = bus.es_i_branch &
                       (((bus.es_i_alu_op == OP_BEQ) & w_zero) |
                        ((bus.es_i_alu_op == OP_BNE) & ~w_zero));
    assign w_accept  = bus.es_i_ce & ~w_stall;

    always_comb begin
        w_alu = '0;
        case (bus.es_i_alu_op)
            OP_RTYPE: begin
                case (bus.es_i_alu_funct)
                    F_ADD:   w_alu = w_a + w_b;
                    F_SUB:   w_alu = w_diff;
                    F_AND:   w_alu = w_a & w_b;
                    F_OR:    w_alu = w_a | w_b;
                    F_SLT:   w_alu = DWIDTH'($signed(w_a) < $signed(w_b));
                    F_MFHI:  w_alu = r_hi;
                    F_MFLO:  w_alu = r_lo;
                    default: w_alu = '0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: w_alu = w_a + w_imm_ext;
            OP_BEQ, OP_BNE:        w_alu = w_diff;
            default:               w_alu = '0;
        endcase
    end

    // Multiply/divide decode; signed ops work on magnitudes
    assign w_is_md  = (bus.es_i_alu_op == OP_RTYPE) &
                      ((bus.es_i_alu_funct == F_MULT) |
                       (bus.es_i_alu_funct == F_MULTU) |
                       (bus.es_i_alu_funct == F_DIV) |
                       (bus.es_i_alu_funct == F_DIVU));
    assign w_md_div = bus.es_i_alu_funct[1];
    assign w_md_sgn = ~bus.es_i_alu_funct[0];
    assign w_div0   = w_md_div & (bus.es_i_data_rt == '0);
    assign w_rs_neg = w_md_sgn & bus.es_i_data_rs[DWIDTH-1];
    assign w_rt_neg = w_md_sgn & bus.es_i_data_rt[DWIDTH-1];
    assign w_rs_mag = w_rs_neg ? -bus.es_i_data_rs : bus.es_i_data_rs;
    assign w_rt_mag = w_rt_neg ? -bus.es_i_data_rt : bus.es_i_data_rt;

    // One iteration: shift-add for multiply, restoring subtract for divide
    assign w_sum = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_mcand} : '0);
    assign w_shl = {r_ph, r_pl[DWIDTH-1]};
    assign w_ge  = (w_shl >= {1'b0, r_mcand});

    always_comb begin
        w_ph_n = w_sum[DWIDTH:1];
        w_pl_n = {w_sum[0], r_pl[DWIDTH-1:1]};
        if (r_is_div) begin
            w_ph_n = w_ge ? DWIDTH'(w_shl - {1'b0, r_mcand})
                          : w_shl[DWIDTH-1:0];
            w_pl_n = {r_pl[DWIDTH-2:0], w_ge};
        end
    end

    assign w_prod = r_neg_q ? -{w_ph_n, w_pl_n} : {w_ph_n, w_pl_n};

    always_comb begin
        w_hi_res = w_prod[2*DWIDTH-1:DWIDTH];
        w_lo_res = w_prod[DWIDTH-1:0];
        if (r_is_div) begin
            w_hi_res = r_neg_r ? -w_ph_n : w_ph_n;
            w_lo_res = r_neg_q ? -w_pl_n : w_pl_n;
        end
    end

    // FSM: state register
    always_ff @(posedge es_clk) begin
        if (es_rst) r_state <= S_IDLE;
        else        r_state <= w_state_n;
    end

    // FSM: next state
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE: if (w_accept & w_is_md & ~w_div0) w_state_n = S_BUSY;
            S_BUSY: if (r_cnt == CW'(1))              w_state_n = S_IDLE;
            default:                                  w_state_n = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_stall = (r_state == S_BUSY);
        w_done  = (r_state == S_BUSY) & (r_cnt == CW'(1));
    end

    always_ff @(posedge es_clk) begin
        if (es_rst) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_ph     <= '0;
            r_pl     <= '0;
            r_mcand  <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_val    <= '0;
            r_pc     <= '0;
            r_op     <= '0;
            r_funct  <= '0;
            r_zero   <= 1'b0;
            r_ce     <= 1'b0;
            r_chg    <= 1'b0;
        end else begin
            r_ce  <= 1'b0;
            r_chg <= 1'b0;
            if (w_stall) begin
                r_cnt <= r_cnt - CW'(1);
                r_ph  <= w_ph_n;
                r_pl  <= w_pl_n;
                if (w_done) begin
                    r_hi  <= w_hi_res;
                    r_lo  <= w_lo_res;
                    r_val <= '0;
                    r_ce  <= 1'b1;
                end
            end else if (w_accept) begin
                r_op    <= bus.es_i_alu_op;
                r_funct <= bus.es_i_alu_funct;
                r_pc    <= w_br_pc;
                r_zero  <= w_zero;
                if (w_is_md & w_div0) begin
                    r_hi  <= bus.es_i_data_rs;
                    r_lo  <= '1;
                    r_val <= '0;
                    r_ce  <= 1'b1;
                end else if (w_is_md) begin
                    r_cnt    <= CW'(DWIDTH);
                    r_ph     <= '0;
                    r_pl     <= w_md_div ? w_rs_mag : w_rt_mag;
                    r_mcand  <= w_md_div ? w_rt_mag : w_rs_mag;
                    r_is_div <= w_md_div;
                    r_neg_q  <= w_rs_neg ^ w_rt_neg;
                    r_neg_r  <= w_rs_neg;
                end else begin
                    r_val <= w_alu;
                    r_ce  <= 1'b1;
                    r_chg <= w_chg;
                end
            end
        end
    end

    assign bus.es_o_alu_value = r_val;
    assign bus.es_o_alu_pc    = r_pc;
    assign bus.es_o_opcode    = r_op;
    assign bus.es_o_funct     = r_funct;
    assign bus.es_o_zero      = r_zero;
    assign bus.es_o_ce        = r_ce;
    assign bus.es_o_change_pc = r_chg;
    assign bus.es_o_stall     = w_stall;
endmodule

// File: tb/tb_execute_muldiv.sv
// Directed vector bench for execute_muldiv: ALU table plus
// multiply/divide, divide-by-zero, reset-abort and held-issue sequences.
module tb_execute_muldiv;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    execute_muldiv_if bus ();

    execute_muldiv dut (
        .es_clk (clk),
        .es_rst (rst),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        src;
        logic        br;
        logic [31:0] pc;
        logic [15:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] val;
        logic [31:0] npc;
        logic        zero;
        logic        chg;
    } vec_t;

    vec_t v[17];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] funct,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] imm, input logic [31:0] pc,
                         input logic br, input logic src);
        bus.es_i_alu_op    = op;
        bus.es_i_alu_funct = funct;
        bus.es_i_data_rs   = rs;
        bus.es_i_data_rt   = rt;
        bus.es_i_imm       = imm;
        bus.es_i_pc        = pc;
        bus.es_i_branch    = br;
        bus.es_i_alu_src   = src;
        bus.es_i_ce        = 1'b1;
    endtask

    task automatic rtype(input logic [5:0] funct, input logic [31:0] rs,
                         input logic [31:0] rt);
        drive(6'h00, funct, rs, rt, 16'h0, 32'h0, 1'b0, 1'b0);
        step();
        bus.es_i_ce = 1'b0;
    endtask

    task automatic rd(input logic [5:0] funct, input string name,
                      input logic [31:0] exp);
        rtype(funct, 32'h0, 32'h0);
        chk(name, bus.es_o_alu_value, exp);
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        while (bus.es_o_stall === 1'b1 && cyc < 200) begin
            cyc++;
            step();
        end
        chk({name, "_stall_cycles"}, cyc, 32);
        chk({name, "_done_ce"}, bus.es_o_ce, 1'b1);
        chk({name, "_done_val"}, bus.es_o_alu_value, 32'h0);
    endtask

    initial begin
        v[0]  = '{6'h00, 6'h20, 0, 0, 32'd0,  16'h0000, 32'd5,
                  32'd4, 32'd9, 32'd4, 0, 0};
        v[1]  = '{6'h00, 6'h22, 0, 0, 32'd0,  16'h0000, 32'd5,
                  32'd4, 32'd1, 32'd4, 0, 0};
        v[2]  = '{6'h00, 6'h24, 0, 0, 32'd0,  16'h0000, 32'h0000F0F0,
                  32'h0000FF00, 32'h0000F000, 32'd4, 0, 0};
        v[3]  = '{6'h00, 6'h25, 0, 0, 32'd0,  16'h0000, 32'h0000F0F0,
                  32'h0000FF00, 32'h0000FFF0, 32'd4, 0, 0};
        v[4]  = '{6'h00, 6'h2A, 0, 0, 32'd0,  16'h0000, 32'hFFFFFFFF,
                  32'd1, 32'd1, 32'd4, 0, 0};
        v[5]  = '{6'h00, 6'h2A, 0, 0, 32'd0,  16'h0000, 32'd1,
                  32'hFFFFFFFF, 32'd0, 32'd4, 0, 0};
        v[6]  = '{6'h08, 6'h00, 1, 0, 32'd0,  16'hFFFF, 32'd100,
                  32'd0, 32'd99, 32'd0, 0, 0};
        v[7]  = '{6'h23, 6'h00, 1, 0, 32'd0,  16'h0008, 32'h00001000,
                  32'd0, 32'h00001008, 32'h24, 0, 0};
        v[8]  = '{6'h04, 6'h00, 0, 1, 32'd10, 16'd10, 32'd5,
                  32'd5, 32'd0, 32'd54, 1, 1};
        v[9]  = '{6'h05, 6'h00, 0, 1, 32'd10, 16'd10, 32'd5,
                  32'd5, 32'd0, 32'd54, 1, 0};
        v[10] = '{6'h05, 6'h00, 0, 1, 32'd0,  16'h0000, 32'd5,
                  32'd3, 32'd2, 32'd4, 0, 1};
        v[11] = '{6'h3F, 6'h00, 0, 0, 32'd0,  16'h0000, 32'd5,
                  32'd4, 32'd0, 32'd4, 0, 0};
        v[12] = '{6'h00, 6'h20, 0, 0, 32'd0,  16'h0000, 32'h7FFFFFFF,
                  32'd1, 32'h80000000, 32'd4, 0, 0};
        v[13] = '{6'h04, 6'h00, 0, 1, 32'd0,  16'hFFFF, 32'd9,
                  32'd9, 32'd0, 32'd0, 1, 1};
        v[14] = '{6'h00, 6'h3F, 0, 0, 32'd0,  16'h0000, 32'd5,
                  32'd5, 32'd0, 32'd4, 1, 0};
        v[15] = '{6'h04, 6'h00, 0, 0, 32'd0,  16'h0000, 32'd7,
                  32'd7, 32'd0, 32'd4, 1, 0};
        v[16] = '{6'h2B, 6'h00, 1, 0, 32'd0,  16'hFFF0, 32'h20,
                  32'd0, 32'h10, 32'hFFFFFFC4, 0, 0};

        drive(6'h00, 6'h00, 32'h0, 32'h0, 16'h0, 32'h0, 1'b0, 1'b0);
        bus.es_i_ce = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_val",   bus.es_o_alu_value, 32'h0);
        chk("rst_pc",    bus.es_o_alu_pc, 32'h0);
        chk("rst_ce",    bus.es_o_ce, 1'b0);
        chk("rst_stall", bus.es_o_stall, 1'b0);
        chk("rst_zero",  bus.es_o_zero, 1'b0);
        chk("rst_chg",   bus.es_o_change_pc, 1'b0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 17; i++) begin
            drive(v[i].op, v[i].funct, v[i].rs, v[i].rt, v[i].imm,
                  v[i].pc, v[i].br, v[i].src);
            step();
            bus.es_i_ce = 1'b0;
            chk($sformatf("v%0d_val", i), bus.es_o_alu_value, v[i].val);
            chk($sformatf("v%0d_ce", i), bus.es_o_ce, 1'b1);
            chk($sformatf("v%0d_pc", i), bus.es_o_alu_pc, v[i].npc);
            chk($sformatf("v%0d_zero", i), bus.es_o_zero, v[i].zero);
            chk($sformatf("v%0d_chg", i), bus.es_o_change_pc, v[i].chg);
            chk($sformatf("v%0d_op", i), bus.es_o_opcode, v[i].op);
            chk($sformatf("v%0d_fn", i), bus.es_o_funct, v[i].funct);
        end

        step();
        chk("idle_ce",  bus.es_o_ce, 1'b0);
        chk("idle_val", bus.es_o_alu_value, v[16].val);

        rtype(6'h18, 32'hFFFFFFFD, 32'd7);
        chk("mult_stall", bus.es_o_stall, 1'b1);
        chk("mult_ce0", bus.es_o_ce, 1'b0);
        wait_done("mult");
        rd(6'h10, "mult_hi", 32'hFFFFFFFF);
        rd(6'h12, "mult_lo", 32'hFFFFFFEB);

        rtype(6'h19, 32'hFFFFFFFF, 32'd2);
        wait_done("multu");
        rd(6'h10, "multu_hi", 32'h00000001);
        rd(6'h12, "multu_lo", 32'hFFFFFFFE);

        rtype(6'h1A, 32'hFFFFFFF9, 32'd2);
        wait_done("div");
        rd(6'h12, "div_lo", 32'hFFFFFFFD);
        rd(6'h10, "div_hi", 32'hFFFFFFFF);

        rtype(6'h1B, 32'd100, 32'd7);
        wait_done("divu");
        rd(6'h12, "divu_lo", 32'd14);
        rd(6'h10, "divu_hi", 32'd2);

        rtype(6'h1A, 32'h80000000, 32'hFFFFFFFF);
        wait_done("divmin");
        rd(6'h12, "divmin_lo", 32'h80000000);
        rd(6'h10, "divmin_hi", 32'h0);

        rtype(6'h1B, 32'd7, 32'd0);
        chk("div0_stall", bus.es_o_stall, 1'b0);
        chk("div0_ce", bus.es_o_ce, 1'b1);
        chk("div0_val", bus.es_o_alu_value, 32'h0);
        rd(6'h10, "div0_hi", 32'd7);
        rd(6'h12, "div0_lo", 32'hFFFFFFFF);

        rtype(6'h19, 32'hFFFFFFFF, 32'd2);
        repeat (9) step();
        chk("abort_busy", bus.es_o_stall, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_stall", bus.es_o_stall, 1'b0);
        chk("abort_ce",    bus.es_o_ce, 1'b0);
        chk("abort_pc",    bus.es_o_alu_pc, 32'h0);
        chk("abort_fn",    bus.es_o_funct, 6'h0);
        chk("abort_val",   bus.es_o_alu_value, 32'h0);
        step();
        chk("abort_stays_idle", bus.es_o_stall, 1'b0);
        rd(6'h12, "abort_lo", 32'h0);
        rd(6'h10, "abort_hi", 32'h0);

        drive(6'h00, 6'h18, 32'd2, 32'd3, 16'h0, 32'h0, 1'b0, 1'b0);
        step();
        drive(6'h00, 6'h20, 32'd5, 32'd4, 16'h0, 32'h0, 1'b0, 1'b0);
        wait_done("held");
        chk("held_fn_before", bus.es_o_funct, 6'h18);
        step();
        bus.es_i_ce = 1'b0;
        chk("held_add_ce",  bus.es_o_ce, 1'b1);
        chk("held_add_val", bus.es_o_alu_value, 32'd9);
        chk("held_add_fn",  bus.es_o_funct, 6'h20);
        step();
        chk("held_once_ce", bus.es_o_ce, 1'b0);
        rd(6'h12, "held_lo", 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
